// File: rtl/ad9625_capture_packetizer.sv
// rtl/ad9625_capture_packetizer.sv - AD9625 beat capture with optional trigger, FWFT FIFO and AXI-Stream packet output
module ad9625_capture_packetizer #(
  parameter int FIFO_AW    = 4,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  adc_clk,
  input  logic                  adc_rstn,
  input  logic                  adc_valid,
  input  logic                  adc_enable,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  adc_dovf,
  input  logic                  trig_in,
  input  logic                  cfg_arm,
  input  logic                  cfg_trig_en,
  input  logic [15:0]           cfg_pkt_len,
  output logic                  status_busy,
  output logic                  capture_done,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [15:0]           r_len_q;
  logic [15:0]           r_beat_cnt;
  logic                  r_trig_d;
  logic [FIFO_AW:0]      r_wr_ptr;
  logic [FIFO_AW:0]      r_rd_ptr;
  logic                  r_dovf;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic                  r_last_mem [DEPTH];

  logic                  w_edge;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_eligible;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_last_beat;
  logic                  w_drain_done;
  logic [FIFO_AW:0]      w_rd_next;

  assign w_edge      = trig_in & ~r_trig_d;
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]) &&
                       (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]);
  // The beat coincident with the trigger edge is already eligible while still ARMED.
  assign w_eligible  = adc_valid & adc_enable &
                       ((r_state == S_CAPTURE) | ((r_state == S_ARMED) & w_edge));
  assign w_wr        = w_eligible & ~w_full;
  assign w_pop       = ~w_empty & m_axis_ready;
  assign w_last_beat = (r_beat_cnt == r_len_q);
  assign w_rd_next   = r_rd_ptr + PTR_ONE;
  assign w_drain_done = w_empty | (w_pop & (w_rd_next == r_wr_ptr));

  assign m_axis_valid = ~w_empty;
  assign m_axis_data  = w_empty ? '0 : r_data_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign m_axis_last  = ~w_empty & r_last_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign status_busy  = (r_state != S_IDLE);
  assign capture_done = r_done;
  assign adc_dovf     = r_dovf;

  always_ff @(posedge adc_clk) begin
    if (w_wr) begin
      r_data_mem[r_wr_ptr[FIFO_AW-1:0]] <= adc_data;
      r_last_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_last_beat;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!adc_rstn) begin
      r_state    <= S_IDLE;
      r_len_q    <= 16'd0;
      r_beat_cnt <= 16'd0;
      r_trig_d   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_dovf     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_trig_d <= trig_in;
      r_dovf   <= w_eligible & w_full;
      r_done   <= 1'b0;
      if (w_wr) begin
        r_wr_ptr   <= r_wr_ptr + PTR_ONE;
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      case (r_state)
        S_IDLE: begin
          if (cfg_arm) begin
            r_len_q    <= cfg_pkt_len;
            r_beat_cnt <= 16'd0;
            r_state    <= cfg_trig_en ? S_ARMED : S_CAPTURE;
          end
        end
        S_ARMED: begin
          if (w_edge) begin
            r_state <= (w_wr && w_last_beat) ? S_FLUSH : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (w_wr && w_last_beat) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_drain_done) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9625_capture_packetizer.sv
// tb/tb_ad9625_capture_packetizer.sv - vector table, directed sequences and random stimulus against a queue-based model
module tb_ad9625_capture_packetizer;

  localparam int AW    = 4;
  localparam int DW    = 256;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rstn;
  logic          valid;
  logic          en;
  logic [DW-1:0] data;
  logic          adc_dovf;
  logic          trig;
  logic          arm;
  logic          trig_en;
  logic [15:0]   len;
  logic          status_busy;
  logic          capture_done;
  logic          m_axis_valid;
  logic          ready;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_last;

  ad9625_capture_packetizer #(.FIFO_AW(AW), .DATA_WIDTH(DW)) dut (
    .adc_clk      (clk),
    .adc_rstn     (rstn),
    .adc_valid    (valid),
    .adc_enable   (en),
    .adc_data     (data),
    .adc_dovf     (adc_dovf),
    .trig_in      (trig),
    .cfg_arm      (arm),
    .cfg_trig_en  (trig_en),
    .cfg_pkt_len  (len),
    .status_busy  (status_busy),
    .capture_done (capture_done),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (ready),
    .m_axis_data  (m_axis_data),
    .m_axis_last  (m_axis_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rstn, arm, trig_en;
    logic [15:0] len;
    logic valid, en, trig;
    logic [7:0] d;
    logic ready;
    logic e_valid, e_last;
    logic [7:0] e_d;
    logic e_busy, e_done, e_dovf;
  } vec_t;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue for the FIFO, a phase (0 idle, 1 waiting trigger,
  // 2 capturing, 3 draining) and a count of beats still owed to the packet.
  beat_t m_fifo[$];
  int    m_phase;
  int    m_remaining;
  logic  m_trig_prev;
  logic  m_dovf;
  logic  m_done;

  int            n_out, n_last, n_done, n_dovf;
  logic [DW-1:0] first_out;
  logic          got_first;

  function automatic logic [DW-1:0] pat(input logic [15:0] v);
    return {16{v}};
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_update();
    logic  edge_s, elig, full_b;
    int    phase_pre;
    beat_t b;
    if (!rstn) begin
      m_fifo.delete();
      m_phase = 0; m_remaining = 0; m_trig_prev = 1'b0; m_dovf = 1'b0; m_done = 1'b0;
      return;
    end
    edge_s    = trig & ~m_trig_prev;
    phase_pre = m_phase;
    full_b    = (m_fifo.size() == DEPTH);
    elig      = valid & en & ((m_phase == 2) || ((m_phase == 1) && edge_s));
    m_dovf    = elig & full_b;
    m_done    = 1'b0;
    if (m_fifo.size() > 0 && ready) void'(m_fifo.pop_front());
    if (elig && !full_b) begin
      b.last = (m_remaining == 1);
      b.data = data;
      m_fifo.push_back(b);
      m_remaining--;
      m_phase = (m_remaining == 0) ? 3 : 2;
    end else if (m_phase == 1 && edge_s) begin
      m_phase = 2;
    end
    if (phase_pre == 3 && m_fifo.size() == 0) begin
      m_done = 1'b1; m_phase = 0;
    end
    if (phase_pre == 0 && arm) begin
      m_remaining = int'(len) + 1;
      m_phase = trig_en ? 1 : 2;
    end
    m_trig_prev = trig;
  endtask

  task automatic check_outputs(input string tag);
    logic          ev, el, eb;
    logic [DW-1:0] ed;
    ev = (m_fifo.size() > 0);
    ed = ev ? m_fifo[0].data : '0;
    el = ev ? m_fifo[0].last : 1'b0;
    eb = (m_phase != 0);
    n_vec++;
    if (m_axis_valid !== ev || m_axis_last !== el || m_axis_data !== ed ||
        status_busy !== eb || capture_done !== m_done || adc_dovf !== m_dovf) begin
      n_err++;
      $display("FAIL %s t=%0t valid=%b/%b last=%b/%b data[31:0]=%h/%h busy=%b/%b done=%b/%b dovf=%b/%b (got/exp)",
               tag, $time, m_axis_valid, ev, m_axis_last, el, m_axis_data[31:0], ed[31:0],
               status_busy, eb, capture_done, m_done, adc_dovf, m_dovf);
    end
  endtask

  task automatic step(input string tag);
    if (rstn && m_axis_valid && ready) begin
      n_out++;
      if (m_axis_last) n_last++;
      if (!got_first) begin first_out = m_axis_data; got_first = 1'b1; end
    end
    model_update();
    @(posedge clk); #1;
    if (capture_done) n_done++;
    if (adc_dovf) n_dovf++;
    check_outputs(tag);
  endtask

  task automatic check_count(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_out = 0; n_last = 0; n_done = 0; n_dovf = 0; got_first = 1'b0; first_out = '0;
  endtask

  task automatic idle_inputs();
    arm = 1'b0; valid = 1'b0; en = 1'b1; trig = 1'b0; ready = 1'b1; data = '0;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0,16'd0, 1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,16'd1, 1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,16'd1, 1'b1,1'b1,1'b0,8'hA1,1'b0, 1'b1,1'b0,8'hA1,1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,16'd1, 1'b1,1'b1,1'b0,8'hA2,1'b0, 1'b1,1'b0,8'hA1,1'b1,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,16'd1, 1'b1,1'b1,1'b0,8'hA3,1'b1, 1'b1,1'b1,8'hA2,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b0,16'd1, 1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b0,1'b1,1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b0,16'd1, 1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b1,16'd0, 1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b1,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b1,16'd0, 1'b1,1'b1,1'b0,8'hB0,1'b1, 1'b0,1'b0,8'h00,1'b1,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b1,16'd0, 1'b1,1'b1,1'b1,8'hB1,1'b0, 1'b1,1'b1,8'hB1,1'b1,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b1,1'b0,16'd5, 1'b1,1'b1,1'b1,8'hB2,1'b0, 1'b1,1'b1,8'hB1,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,16'd5, 1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b0,1'b1,1'b0};

    for (int i = 0; i < 12; i++) begin
      logic [DW-1:0] ed;
      rstn = tbl[i].rstn; arm = tbl[i].arm; trig_en = tbl[i].trig_en; len = tbl[i].len;
      valid = tbl[i].valid; en = tbl[i].en; trig = tbl[i].trig; ready = tbl[i].ready;
      data = {32{tbl[i].d}};
      ed = {32{tbl[i].e_d}};
      @(posedge clk); #1;
      n_vec++;
      if (m_axis_valid !== tbl[i].e_valid || m_axis_last !== tbl[i].e_last || m_axis_data !== ed ||
          status_busy !== tbl[i].e_busy || capture_done !== tbl[i].e_done || adc_dovf !== tbl[i].e_dovf) begin
        n_err++;
        $display("FAIL table[%0d] valid=%b/%b last=%b/%b data[7:0]=%h/%h busy=%b/%b done=%b/%b dovf=%b/%b (got/exp)",
                 i, m_axis_valid, tbl[i].e_valid, m_axis_last, tbl[i].e_last, m_axis_data[7:0], tbl[i].e_d,
                 status_busy, tbl[i].e_busy, capture_done, tbl[i].e_done, adc_dovf, tbl[i].e_dovf);
      end
    end

    idle_inputs(); trig_en = 1'b0; len = 16'd0;
    rstn = 1'b0; step("reset"); rstn = 1'b1;

    // Immediate capture of 8 beats at full rate.
    clear_counts();
    arm = 1'b1; trig_en = 1'b0; len = 16'd7; step("imm_arm"); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin valid = 1'b1; data = pat(16'(i)); step("imm"); end
    valid = 1'b0;
    check_count("imm_out", n_out, 8);
    check_count("imm_last", n_last, 1);
    check_count("imm_done", n_done, 1);
    check_count("imm_busy", int'(status_busy), 0);

    // Triggered capture starting at beat 0x20.
    clear_counts();
    arm = 1'b1; trig_en = 1'b1; len = 16'd3; step("trg_arm"); arm = 1'b0;
    for (int v = 0; v < 'h30; v++) begin
      valid = 1'b1; data = pat(16'(v)); trig = (v >= 'h20); step("trg");
    end
    valid = 1'b0; trig = 1'b0;
    check_count("trg_first_is_0x20", int'(first_out == pat(16'h20)), 1);
    check_count("trg_out", n_out, 4);
    check_count("trg_done", n_done, 1);

    // Backpressure overflow: 20 beats into a 16-deep FIFO.
    clear_counts();
    arm = 1'b1; trig_en = 1'b0; len = 16'd31; step("ovf_arm"); arm = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin valid = 1'b1; data = pat(16'(16'h100 + i)); step("ovf_fill"); end
    check_count("ovf_dovf", n_dovf, 4);
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin valid = 1'b1; data = pat(16'(16'h200 + i)); step("ovf_drain"); end
    valid = 1'b0;
    for (int i = 0; i < 5; i++) step("ovf_tail");
    check_count("ovf_out", n_out, 32);
    check_count("ovf_last", n_last, 1);
    check_count("ovf_done", n_done, 1);

    // Enable gaps.
    clear_counts();
    arm = 1'b1; len = 16'd4; step("gap_arm"); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin valid = 1'b1; en = (i % 2 == 0); data = pat(16'(16'h300 + i)); step("gap"); end
    valid = 1'b0; en = 1'b1;
    check_count("gap_out", n_out, 5);
    check_count("gap_dovf", n_dovf, 0);

    // Arm during capture is ignored; a later single-beat packet carries last.
    clear_counts();
    arm = 1'b1; len = 16'd5; step("rearm_arm");
    for (int i = 0; i < 12; i++) begin
      arm = (i == 3); if (i == 3) len = 16'd0;
      valid = 1'b1; data = pat(16'(16'h400 + i)); step("rearm");
    end
    arm = 1'b0; valid = 1'b0;
    check_count("rearm_out", n_out, 6);
    clear_counts();
    arm = 1'b1; len = 16'd0; step("single_arm"); arm = 1'b0;
    for (int i = 0; i < 5; i++) begin valid = 1'b1; data = pat(16'(16'h500 + i)); step("single"); end
    valid = 1'b0;
    check_count("single_out", n_out, 1);
    check_count("single_last", n_last, 1);

    // Reset with 6 beats buffered.
    clear_counts();
    arm = 1'b1; len = 16'd20; ready = 1'b0; step("rst_arm"); arm = 1'b0;
    for (int i = 0; i < 6; i++) begin valid = 1'b1; data = pat(16'(16'h600 + i)); step("rst_fill"); end
    valid = 1'b0; rstn = 1'b0; step("rst_pulse"); rstn = 1'b1;
    check_count("rst_valid", int'(m_axis_valid), 0);
    for (int i = 0; i < 3; i++) step("rst_after");
    check_count("rst_done", n_done, 0);
    ready = 1'b1;
    arm = 1'b1; len = 16'd2; step("rst_rearm"); arm = 1'b0;
    for (int i = 0; i < 8; i++) begin valid = 1'b1; data = pat(16'(16'h700 + i)); step("rst_cap"); end
    valid = 1'b0;
    check_count("rst_cap_out", n_out, 3);
    check_count("rst_cap_done", n_done, 1);

    // Randomized traffic against the model.
    begin
      int rdy_pct = 90;
      for (int c = 0; c < 4000; c++) begin
        if (c % 200 == 0) rdy_pct = (($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 95));
        rstn    = ($urandom_range(0, 999) != 0);
        arm     = ($urandom_range(0, 15) == 0);
        trig_en = 1'($urandom_range(0, 1));
        len     = 16'($urandom_range(0, 40));
        valid   = ($urandom_range(0, 3) != 0);
        en      = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 9) == 0) trig = ~trig;
        ready   = ($urandom_range(0, 99) < rdy_pct);
        data    = rnd_data();
        step("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ad9625_capture_packetizer.md
# ad9625_capture_packetizer

Downstream consumer of the AD9625 core's DMA interface: takes the 256-bit sample-beat stream (16 × 16-bit samples per beat) on adc_clk and captures a programmed number of beats, optionally after a trigger edge. It buffers them in a small FIFO and emits them as an AXI-Stream packet with TLAST on the final beat. It reports dropped beats back to the core through adc_dovf and signals completion to software-side status logic.

## Interface
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW beats
- DATA_WIDTH, 256, beat width in bits
- adc_clk  in  1  single clock for all logic
- adc_rstn  in  1  reset, synchronous, active-low
- adc_valid  in  1  beat qualifier from core
- adc_enable  in  1  channel enable from core; beats ignored when low
- adc_data  in  DATA_WIDTH  sample beat
- adc_dovf  out  1  one-cycle pulse per dropped beat
- trig_in  in  1  external trigger, already in adc_clk domain
- cfg_arm  in  1  start pulse
- cfg_trig_en  in  1  1: wait for trigger rising edge; 0: capture immediately
- cfg_pkt_len  in  16  packet length minus 1, in beats
- status_busy  out  1  high whenever state is not IDLE
- capture_done  out  1  one-cycle pulse at end of capture
- m_axis_valid  out  1  stream valid
- m_axis_ready  in  1  stream ready
- m_axis_data  out  DATA_WIDTH  stream data
- m_axis_last  out  1  high on final beat of packet

## Operation
- States: IDLE, ARMED, CAPTURE, FLUSH.
- IDLE, cfg_arm=1:
  - Latch cfg_pkt_len into len_q and clear beat_cnt.
  - Go to ARMED if cfg_trig_en=1, else CAPTURE.
- cfg_arm is ignored in every state except IDLE.
- Trigger edge: trig_d is trig_in registered. edge = trig_in & ~trig_d.
- ARMED: on edge, go to CAPTURE. The beat present in the edge cycle is eligible as beat 0.
- Write-eligible beat: adc_valid & adc_enable, in CAPTURE or in ARMED with edge.
- Eligible beat, FIFO not full:
  - Write {last, data}, with last = (beat_cnt == len_q).
  - beat_cnt increments.
  - If last, go to FLUSH.
- Eligible beat, FIFO full:
  - Drop the beat and pulse adc_dovf.
  - beat_cnt does not advance, so the packet always carries exactly len_q+1 beats.
- adc_enable=0 during CAPTURE: beats ignored, state held, no adc_dovf.
- FLUSH:
  - Accept no writes.
  - When the FIFO is empty, pulse capture_done and go to IDLE.
- FIFO:
  - Register array, first-word-fall-through.
  - Pointers are FIFO_AW+1 bits and wrap naturally.
  - full = pointers equal in low bits and differ in MSB. empty = pointers fully equal.
  - full is evaluated before the same-cycle read: a write is refused when full even if a pop occurs in the same cycle.
  - Pop occurs on m_axis_valid & m_axis_ready.
- m_axis_valid = !empty. m_axis_data and m_axis_last come from the read-pointer entry and are stable while valid & !ready.
- cfg_pkt_len is 16 bits: packet length 1..65536 beats. beat_cnt is 16 bits and never wraps within a packet.

## Timing
- Reset (adc_rstn=0 at a clock edge):
  - State goes to IDLE, both pointers and beat_cnt to 0, trig_d to 0.
  - Outputs low: adc_dovf, status_busy, capture_done, m_axis_valid, m_axis_last. m_axis_data is 0.
- Reset mid-capture discards all buffered beats; no capture_done is issued.
- Latencies:
  - Beat written at edge t: m_axis_valid is high in cycle t+1.
  - Pop at edge t: the next entry is presented in cycle t+1.
  - Trigger: trig_in going high in cycle t (low in t-1) makes the cycle-t beat beat 0.
  - Arm: cfg_arm at edge t makes status_busy high from t+1. The first possible write with cfg_trig_en=0 is the beat at t+1.
- Throughput is 1 beat/cycle in and out; full rate is sustained with m_axis_ready held high.
- capture_done is asserted in the cycle after the final pop empties the FIFO, together with status_busy falling.
- adc_dovf is registered: asserted in the cycle after the dropped beat was presented.

## Test plan
- Immediate capture: cfg_trig_en=0, cfg_pkt_len=7, continuous valid beats, ready=1 → exactly 8 beats out, data matching input order, m_axis_last only on beat 8, capture_done once, status_busy low afterwards.
- Triggered capture: cfg_trig_en=1, cfg_pkt_len=3, incrementing beat pattern, trig_in rises while beat value 0x20 is presented → output beats 0x20..0x23, last on 0x23. No output before the trigger.
- Backpressure overflow: FIFO_AW=4, cfg_pkt_len=31, ready=0 for 20 cycles of valid beats → 16 beats stored, 4 adc_dovf pulses. After ready=1, 32 beats are eventually output with last on the 32nd and no duplicates.
- Enable gaps: adc_enable toggling 1/0 each cycle, cfg_pkt_len=4 → only enabled beats captured, 5 beats out, no adc_dovf.
- Re-arm and ignore: cfg_arm pulsed during CAPTURE → no effect. A second cfg_arm after capture_done with cfg_pkt_len=0 → a single beat with m_axis_last=1.
- Reset mid-operation: adc_rstn low for 1 cycle with 6 beats buffered → m_axis_valid=0 next cycle, status_busy=0, no capture_done. A subsequent arm works normally.
